// File: rtl/reorder_buffer_if.sv
// Rename/execute/retire bundle for the reorder buffer.
// master = rename + execution side, slave = reorder buffer.
interface reorder_buffer_if #(
   parameter int TAG_W = 4
);
   logic             alloc_valid;
   logic [4:0]       alloc_arch_rd;
   logic [5:0]       alloc_phys_rd;
   logic [5:0]       alloc_old_phys;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             complete_valid;
   logic [TAG_W-1:0] complete_tag;
   logic             retire_valid;
   logic [5:0]       retire_phys_reg;
   logic [4:0]       retire_arch_rd;
   logic [5:0]       retire_phys_rd;
   logic             full;
   logic             empty;
   logic [TAG_W:0]   count;

   modport master (
      output alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys,
      output complete_valid, complete_tag,
      input  alloc_ready, alloc_tag, retire_valid, retire_phys_reg,
      input  retire_arch_rd, retire_phys_rd, full, empty, count
   );

   modport slave (
      input  alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys,
      input  complete_valid, complete_tag,
      output alloc_ready, alloc_tag, retire_valid, retire_phys_reg,
      output retire_arch_rd, retire_phys_rd, full, empty, count
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer; frees superseded physical regs on retire.
// Option: ROB_COMPLETE_BYPASS_EN lets a head completion retire on its own edge.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input logic             clk,
   input logic             reset_n,
   reorder_buffer_if.slave rob
);
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] done;
   logic [4:0]       arch_q [DEPTH];
   logic [5:0]       phys_q [DEPTH];
   logic [5:0]       old_q  [DEPTH];
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;
   logic             full;
   logic             alloc_fire;
   logic             complete_fire;
   logic             retire_fire;

   assign full          = (count == FULL_CNT);
   assign alloc_fire    = rob.alloc_valid && !full;
   assign complete_fire = rob.complete_valid && valid[rob.complete_tag];

`ifdef ROB_COMPLETE_BYPASS_EN
   assign retire_fire = valid[head] &&
      (done[head] || (complete_fire && rob.complete_tag == head));
`else
   assign retire_fire = valid[head] && done[head];
`endif

   assign rob.full        = full;
   assign rob.empty       = (count == '0);
   assign rob.alloc_ready = !full;
   assign rob.alloc_tag   = tail;
   assign rob.count       = count;

   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         arch_q[tail] <= rob.alloc_arch_rd;
         phys_q[tail] <= rob.alloc_phys_rd;
         old_q[tail]  <= rob.alloc_old_phys;
      end
   end

   // Later writes win: a retiring head drops any same-edge completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid               <= '0;
         done                <= '0;
         head                <= '0;
         tail                <= '0;
         count               <= '0;
         rob.retire_valid    <= 1'b0;
         rob.retire_phys_reg <= '0;
         rob.retire_arch_rd  <= '0;
         rob.retire_phys_rd  <= '0;
      end else begin
         if (complete_fire)
            done[rob.complete_tag] <= 1'b1;
         if (retire_fire) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
            head        <= head + 1'b1;
         end
         if (alloc_fire) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            tail        <= tail + 1'b1;
         end
         unique case ({alloc_fire, retire_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         rob.retire_valid <= retire_fire;
         if (retire_fire) begin
            rob.retire_phys_reg <= old_q[head];
            rob.retire_arch_rd  <= arch_q[head];
            rob.retire_phys_rd  <= phys_q[head];
         end
      end
   end
endmodule
